// File: rtl/seq_det_pkg.sv
// Shared definitions for the frame controller and its serial pattern matcher:
// FSM state encoding and the default pattern.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial, non-overlapping pattern matcher with a registered match flag.
// A hit wipes the history so no matched bit can take part in a later match.
module seq_match_core #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_en,
  input  logic bit_in,
  output logic match
);

  localparam int FILL_W = $clog2(PAT_LEN);

  logic [PAT_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_match;
  logic [PAT_LEN-1:0] w_word;
  logic               w_hit;

  assign w_word = {r_hist, bit_in};
  assign w_hit  = bit_en && (r_fill == FILL_W'(PAT_LEN - 1)) && (w_word == PATTERN);
  assign match  = r_match;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_hit) begin
        r_hist <= '0;
        r_fill <= '0;
      end else if (bit_en) begin
        r_hist <= w_word[PAT_LEN-2:0];
        if (r_fill != FILL_W'(PAT_LEN - 1))
          r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_frame_controller.sv
// Frame controller: accepts a word, shifts it MSB-first through the matcher,
// counts matches and returns the count over a valid/ready result port.
module seq_frame_controller
  import seq_det_pkg::*;
#(
  parameter int                 DATA_W  = 8,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  localparam int                CNT_W   = $clog2(DATA_W / PAT_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_hit,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W + 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_count;
  logic              w_accept;
  logic              w_match;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_next = SHIFT;
          w_accept     = 1'b1;
        end
      end
      SHIFT:   if (r_idx == IDX_W'(DATA_W - 1)) w_state_next = DRAIN;
      DRAIN:   w_state_next = REPORT;
      REPORT:  if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // The DRAIN cycle exists so the registered match of the last bit is counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shreg <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_shreg <= in_data;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      if (r_state == SHIFT) begin
        r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
        r_idx   <= r_idx + IDX_W'(1);
      end
      if (w_match && (r_state == SHIFT || r_state == DRAIN))
        r_count <= r_count + CNT_W'(1);
    end
  end

  seq_match_core #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_match (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_accept),
    .bit_en (r_state == SHIFT),
    .bit_in (r_shreg[DATA_W-1]),
    .match  (w_match)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == REPORT);
  assign busy      = (r_state != IDLE);
  assign out_count = r_count;
  assign out_hit   = (r_count != '0);

endmodule

// File: tb/tb_seq_frame_controller.sv
// Directed bench for seq_frame_controller: latency, counts, frame isolation,
// backpressure and mid-frame reset.
module tb_seq_frame_controller;

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DATA_W / 4 + 1);
  localparam int LAT    = DATA_W + 1;  // edges after accept until out_valid seen

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             in_ready, out_valid, out_hit, busy;
  logic [CNT_W-1:0] out_count;

  int n_tests = 0;
  int n_fail  = 0;

  seq_frame_controller dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_hit   (out_hit),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Offers a frame from an idle point, scrambles in_data after accept and
  // waits (bounded) for out_valid; returns latency and the reported result.
  task automatic send_frame(input logic [DATA_W-1:0] data, output int lat,
                            output logic [CNT_W-1:0] cnt, output logic hit);
    in_data  = data;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~data;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    cnt = out_count;
    hit = out_hit;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({in_ready, out_valid, out_count, out_hit, busy} !== {1'b1, 1'b0, {CNT_W{1'b0}}, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b cnt=%0d hit=%b busy=%b, expected rdy=1 vld=0 cnt=0 hit=0 busy=0",
               in_ready, out_valid, out_count, out_hit, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [CNT_W-1:0] cnt; logic hit;
    out_ready = 1'b1;
    send_frame(8'b1011_1011, lat, cnt, hit);
    n_tests++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL basic_latency: got %0d, expected %0d", lat, LAT);
    end
    n_tests++;
    if (cnt !== 2'd2 || hit !== 1'b1) begin
      n_fail++; $display("FAIL basic_count: got cnt=%0d hit=%b, expected cnt=2 hit=1", cnt, hit);
    end
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy: got busy=%b rdy=%b, expected busy=1 rdy=0", busy, in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_consume: got vld=%b rdy=%b, expected vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_overlap();
    int lat; logic [CNT_W-1:0] cnt; logic hit;
    out_ready = 1'b1;
    send_frame(8'b1011_0110, lat, cnt, hit);
    n_tests++;
    if (lat !== LAT || cnt !== 2'd1 || hit !== 1'b1) begin
      n_fail++; $display("FAIL overlap: got lat=%0d cnt=%0d hit=%b, expected lat=%0d cnt=1 hit=1", lat, cnt, hit, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_ones();
    int lat; logic [CNT_W-1:0] cnt; logic hit;
    logic [DATA_W-1:0] pats [2];
    pats[0] = 8'h00;
    pats[1] = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send_frame(pats[i], lat, cnt, hit);
      n_tests++;
      if (lat !== LAT || cnt !== 2'd0 || hit !== 1'b0) begin
        n_fail++; $display("FAIL zero_ones[%0h]: got lat=%0d cnt=%0d hit=%b, expected lat=%0d cnt=0 hit=0",
                           pats[i], lat, cnt, hit, LAT);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [CNT_W-1:0] cnt; logic hit;
    out_ready = 1'b1;
    send_frame(8'b0000_0101, lat, cnt, hit);
    n_tests++;
    if (lat !== LAT || cnt !== 2'd0) begin
      n_fail++; $display("FAIL b2b_first: got lat=%0d cnt=%0d, expected lat=%0d cnt=0", lat, cnt, LAT);
    end
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: got rdy=%b, expected 1", in_ready);
    end
    send_frame(8'b1000_0000, lat, cnt, hit);
    n_tests++;
    if (lat !== LAT || cnt !== 2'd0 || hit !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d cnt=%0d hit=%b, expected lat=%0d cnt=0 hit=0", lat, cnt, hit, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic [CNT_W-1:0] cnt; logic hit;
    out_ready = 1'b0;
    send_frame(8'b1011_1011, lat, cnt, hit);
    n_tests++;
    if (lat !== LAT || cnt !== 2'd2) begin
      n_fail++; $display("FAIL bp_arrive: got lat=%0d cnt=%0d, expected lat=%0d cnt=2", lat, cnt, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'b1011_0000;
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_count !== 2'd2 || out_hit !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got vld=%b cnt=%0d hit=%b rdy=%b, expected vld=1 cnt=2 hit=1 rdy=0",
                           i, out_valid, out_count, out_hit, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got vld=%b rdy=%b busy=%b, expected vld=0 rdy=1 busy=0",
                         out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int lat; logic [CNT_W-1:0] cnt; logic hit;
    logic seen_valid;
    out_ready = 1'b1;
    in_data   = 8'b1011_1011;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 2'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: got rdy=%b vld=%b cnt=%0d busy=%b, expected rdy=1 vld=0 cnt=0 busy=0",
                         in_ready, out_valid, out_count, busy);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    n_tests++;
    if (seen_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_no_result: got out_valid=1 after reset, expected 0");
    end
    send_frame(8'b1011_0000, lat, cnt, hit);
    n_tests++;
    if (lat !== LAT || cnt !== 2'd1 || hit !== 1'b1) begin
      n_fail++; $display("FAIL midreset_next: got lat=%0d cnt=%0d hit=%b, expected lat=%0d cnt=1 hit=1", lat, cnt, hit, LAT);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_zero_ones();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
